// File: rtl/noise_pkg.sv
// Shared constants and step functions for the noise_gen_mc LFSR/CASR core.
// CASR support in the top is selected by the NOISE_GEN_CASR_EN macro.
package noise_pkg;

  localparam int LFSR_W    = 43;
  localparam int CASR_W    = 37;
  localparam int CASR_R150 = 27;

  localparam logic [LFSR_W-1:0] LFSR_TAPS =
    (LFSR_W'(1) << 41) | (LFSR_W'(1) << 20) | (LFSR_W'(1) << 1);

  localparam logic [31:0] RESET_SEED = 32'd1;

  // Galois-style shift: the bit leaving the top re-enters at bit 0 and the taps.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    logic fb;
    fb = l[LFSR_W-1];
    return {l[LFSR_W-2:0], fb} ^ (fb ? LFSR_TAPS : '0);
  endfunction

  // Cyclic rule 90 everywhere, rule 150 (adds self) at CASR_R150.
  function automatic logic [CASR_W-1:0] casr_step(input logic [CASR_W-1:0] c);
    logic [CASR_W-1:0] from_lo;
    logic [CASR_W-1:0] from_hi;
    logic [CASR_W-1:0] n;
    from_lo      = {c[CASR_W-2:0], c[CASR_W-1]};
    from_hi      = {c[0], c[CASR_W-1:1]};
    n            = from_lo ^ from_hi;
    n[CASR_R150] = n[CASR_R150] ^ c[CASR_R150];
    return n;
  endfunction

endpackage

// File: rtl/noise_chan.sv
// One noise channel: period register, down-counter, held sample and update strobe.
module noise_chan #(
  parameter int OUT_W = 8,
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             cfg_we_i,
  input  logic [PER_W-1:0] cfg_period_i,
  input  logic [OUT_W-1:0] sample_i,
  output logic [OUT_W-1:0] data_o,
  output logic             strb_o
);

  logic [PER_W-1:0] per_q, per_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             strb_q, strb_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    per_d  = per_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    strb_d = 1'b0;
    if (cfg_we_i) per_d = cfg_period_i;
    // Reload reads per_q, so a same-cycle period write only affects the following interval.
    if (ena) begin
      if (cnt_q == '0) begin
        data_d = sample_i;
        cnt_d  = per_q;
        strb_d = 1'b1;
      end else begin
        cnt_d = cnt_q - PER_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together from pre-edge values.
    if (rst) begin
      per_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      strb_q <= 1'b0;
    end else begin
      per_q  <= per_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      strb_q <= strb_d;
    end
  end

  assign data_o = data_q;
  assign strb_o = strb_q;

endmodule

// File: rtl/noise_gen_mc.sv
// Multi-channel noise source: shared LFSR (+ CASR when NOISE_GEN_CASR_EN is defined)
// mixed into a 32-bit word that CHANNELS sample-and-hold dividers slice up.
module noise_gen_mc
  import noise_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int OUT_W    = 8,
  parameter int PER_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        seed_load,
  input  logic [31:0]                 seed,
  input  logic                        cfg_we,
  input  logic [$clog2(CHANNELS)-1:0] cfg_ch,
  input  logic [PER_W-1:0]            cfg_period,
  output logic [31:0]                 mix_o,
  output logic [CHANNELS*OUT_W-1:0]   ch_data,
  output logic [CHANNELS-1:0]         ch_strb
);

  localparam int CH_W = $clog2(CHANNELS);

  if (CHANNELS * OUT_W > 32) begin : g_bad_cfg
    $error("noise_gen_mc: CHANNELS*OUT_W must not exceed 32");
  end

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [31:0]       mix_q, mix_d;
  logic [31:0]       seed_word;

  // An all-zero seed would lock the generator, so it is replaced by the reset seed.
  assign seed_word = (seed == '0) ? RESET_SEED : seed;

  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load)  lfsr_d = LFSR_W'(seed_word);
    else if (ena)   lfsr_d = lfsr_step(lfsr_q);
  end

`ifdef NOISE_GEN_CASR_EN
  logic [CASR_W-1:0] casr_q, casr_d;

  always_comb begin
    casr_d = casr_q;
    if (seed_load)  casr_d = CASR_W'(seed_word);
    else if (ena)   casr_d = casr_step(casr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) casr_q <= CASR_W'(RESET_SEED);
    else     casr_q <= casr_d;
  end

  assign mix_d = ena ? (lfsr_q[31:0] ^ casr_q[31:0]) : mix_q;
`else
  assign mix_d = ena ? lfsr_q[31:0] : mix_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_W'(RESET_SEED);
      mix_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      mix_q  <= mix_d;
    end
  end

  assign mix_o = mix_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic we;
    // Indices at or above CHANNELS match no instance, so such writes fall away.
    assign we = cfg_we && (cfg_ch == CH_W'(i));

    noise_chan #(
      .OUT_W (OUT_W),
      .PER_W (PER_W)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .ena          (ena),
      .cfg_we_i     (we),
      .cfg_period_i (cfg_period),
      .sample_i     (mix_q[i*OUT_W +: OUT_W]),
      .data_o       (ch_data[i*OUT_W +: OUT_W]),
      .strb_o       (ch_strb[i])
    );
  end

endmodule
